// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the IR/valid/ready
// handshake toward the Controller and the redirect input.
interface instr_fetch_unit_if #(
   parameter int DATA_W = 13,
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [DATA_W-1:0] instr_word;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect_en;
   logic [ADDR_W-1:0] redirect_addr;
   logic [CNT_W-1:0]  fetch_cnt;

   modport master (
      output mem_addr, mem_rd, instr_word, opcode, instr_pc, instr_valid, fetch_cnt,
      input  mem_rdata, mem_ack, instr_ready, redirect_en, redirect_addr
   );

   modport slave (
      input  mem_addr, mem_rd, instr_word, opcode, instr_pc, instr_valid, fetch_cnt,
      output mem_rdata, mem_ack, instr_ready, redirect_en, redirect_addr
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns PC/IR, reads memory over req/ack and hands
// the word to the Controller over valid/ready; redirects drain stale fetches.
module instr_fetch_unit #(
   parameter int DATA_W = 13,
   parameter int ADDR_W = 13,
   parameter int CNT_W  = 16
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {FETCH, DRAIN, VALID} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] ipc;
   logic              vld;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc    <= '0;
         ir    <= '0;
         ipc   <= '0;
         vld   <= 1'b0;
         rd    <= 1'b0;
         addr  <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               // rd is low in FETCH only right after reset: issue the first request.
               if (!rd) begin
                  rd <= 1'b1;
                  if (bus.redirect_en) begin
                     pc   <= bus.redirect_addr;
                     addr <= bus.redirect_addr;
                  end else begin
                     addr <= pc;
                  end
               end else if (bus.mem_ack && !bus.redirect_en) begin
                  ir    <= bus.mem_rdata;
                  ipc   <= pc;
                  pc    <= pc + 1'b1;
                  rd    <= 1'b0;
                  vld   <= 1'b1;
                  state <= VALID;
               end else if (bus.mem_ack) begin
                  pc   <= bus.redirect_addr;
                  addr <= bus.redirect_addr;
               end else if (bus.redirect_en) begin
                  // keep addr on the old request until its ack arrives
                  pc    <= bus.redirect_addr;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.redirect_en) pc <= bus.redirect_addr;
               if (bus.mem_ack) begin
                  addr  <= bus.redirect_en ? bus.redirect_addr : pc;
                  state <= FETCH;
               end
            end
            VALID: begin
               if (bus.redirect_en) begin
                  pc    <= bus.redirect_addr;
                  addr  <= bus.redirect_addr;
                  vld   <= 1'b0;
                  rd    <= 1'b1;
                  state <= FETCH;
               end else if (bus.instr_ready) begin
                  if (cnt != '1) cnt <= cnt + 1'b1;
                  addr  <= pc;
                  vld   <= 1'b0;
                  rd    <= 1'b1;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.mem_addr    = addr;
   assign bus.mem_rd      = rd;
   assign bus.instr_word  = ir;
   assign bus.opcode      = ir[DATA_W-1 -: 4];
   assign bus.instr_pc    = ipc;
   assign bus.instr_valid = vld;
   assign bus.fetch_cnt   = cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; counter narrowed to 8 bits so saturation
// is reachable in a short run.
module tb_instr_fetch_unit;
   localparam int DATA_W = 13;
   localparam int ADDR_W = 13;
   localparam int CNT_W  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   instr_fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // auto: zero-wait memory whose word at address a is a ^ 0x1A05
   logic              auto_mem = 1'b1;
   logic              ack_man = 1'b0;
   logic [DATA_W-1:0] rdata_man = '0;
   logic              ready = 1'b0;
   logic              redir = 1'b0;
   logic [ADDR_W-1:0] redir_addr = '0;

   always_comb begin
      bus.mem_ack       = auto_mem ? bus.mem_rd : ack_man;
      bus.mem_rdata     = auto_mem ? (bus.mem_addr ^ 13'h1A05) : rdata_man;
      bus.instr_ready   = ready;
      bus.redirect_en   = redir;
      bus.redirect_addr = redir_addr;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // reset
      step(); step();
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_word", bus.instr_word, 0);
      chk("rst_ipc", bus.instr_pc, 0);
      chk("rst_cnt", bus.fetch_cnt, 0);

      // zero-wait fetch of 0x1A05 at addr 0, ready high
      rst = 1'b0; ready = 1'b1;
      step();
      chk("t1_mem_rd", bus.mem_rd, 1);
      chk("t1_mem_addr", bus.mem_addr, 0);
      step();
      chk("t1_valid", bus.instr_valid, 1);
      chk("t1_word", bus.instr_word, 13'h1A05);
      chk("t1_opcode", bus.opcode, 4'hD);
      chk("t1_ipc", bus.instr_pc, 0);
      chk("t1_rd_low", bus.mem_rd, 0);
      auto_mem = 1'b0; ack_man = 1'b0;
      step();
      chk("t1_next_addr", bus.mem_addr, 1);
      chk("t1_next_rd", bus.mem_rd, 1);
      chk("t1_cnt", bus.fetch_cnt, 1);

      // 3-cycle ack delay at addr 1, then ready low for 5 cycles
      ready = 1'b0;
      step();
      chk("t2_rd_c2", bus.mem_rd, 1);
      chk("t2_addr_c2", bus.mem_addr, 1);
      step();
      chk("t2_rd_c3", bus.mem_rd, 1);
      chk("t2_addr_c3", bus.mem_addr, 1);
      chk("t2_valid_c3", bus.instr_valid, 0);
      ack_man = 1'b1; rdata_man = 13'h0ABC;
      step();
      ack_man = 1'b0;
      chk("t2_valid", bus.instr_valid, 1);
      chk("t2_word", bus.instr_word, 13'h0ABC);
      chk("t2_ipc", bus.instr_pc, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_hold_valid", bus.instr_valid, 1);
         chk("t2_hold_word", bus.instr_word, 13'h0ABC);
         chk("t2_hold_rd", bus.mem_rd, 0);
         chk("t2_hold_cnt", bus.fetch_cnt, 1);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t2_cnt", bus.fetch_cnt, 2);
      chk("t2_next_addr", bus.mem_addr, 2);

      // redirect to 0x40 while fetch of addr 2 is pending; stale ack discarded
      redir = 1'b1; redir_addr = 13'h0040;
      step();
      redir = 1'b0;
      chk("t3_drain_addr", bus.mem_addr, 2);
      chk("t3_drain_rd", bus.mem_rd, 1);
      step();
      chk("t3_drain_addr2", bus.mem_addr, 2);
      ack_man = 1'b1; rdata_man = 13'h1FFF;
      step();
      chk("t3_no_valid", bus.instr_valid, 0);
      chk("t3_new_addr", bus.mem_addr, 13'h0040);
      chk("t3_new_rd", bus.mem_rd, 1);
      rdata_man = 13'h0123;
      step();
      ack_man = 1'b0;
      chk("t3_valid", bus.instr_valid, 1);
      chk("t3_ipc", bus.instr_pc, 13'h0040);
      chk("t3_word", bus.instr_word, 13'h0123);

      // consume, then redirect coincident with ack in FETCH -> re-request at 7
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t4_cnt3", bus.fetch_cnt, 3);
      chk("t4_addr41", bus.mem_addr, 13'h0041);
      redir = 1'b1; redir_addr = 13'h0007; ack_man = 1'b1; rdata_man = 13'h0555;
      step();
      redir = 1'b0;
      chk("t4_coinc_valid", bus.instr_valid, 0);
      chk("t4_coinc_addr", bus.mem_addr, 7);
      chk("t4_coinc_rd", bus.mem_rd, 1);
      rdata_man = 13'h1234;
      step();
      ack_man = 1'b0;
      chk("t4_valid", bus.instr_valid, 1);
      chk("t4_ipc", bus.instr_pc, 7);
      chk("t4_word", bus.instr_word, 13'h1234);
      // redirect and ready together in VALID
      redir = 1'b1; redir_addr = 13'h0100; ready = 1'b1;
      step();
      redir = 1'b0; ready = 1'b0;
      chk("t4_drop_valid", bus.instr_valid, 0);
      chk("t4_no_count", bus.fetch_cnt, 3);
      chk("t4_redir_addr", bus.mem_addr, 13'h0100);

      // PC wrap at 0x1FFF
      redir = 1'b1; redir_addr = 13'h1FFF; ack_man = 1'b1; rdata_man = 13'h0001;
      step();
      redir = 1'b0;
      chk("t5_addr_top", bus.mem_addr, 13'h1FFF);
      rdata_man = 13'h0777;
      step();
      ack_man = 1'b0;
      chk("t5_ipc", bus.instr_pc, 13'h1FFF);
      chk("t5_word", bus.instr_word, 13'h0777);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t5_wrap_addr", bus.mem_addr, 0);
      chk("t5_cnt", bus.fetch_cnt, 4);

      // reset for one cycle during DRAIN with ack pending
      redir = 1'b1; redir_addr = 13'h0055;
      step();
      redir = 1'b0;
      chk("t6_drain_addr", bus.mem_addr, 0);
      rst = 1'b1; ack_man = 1'b1; rdata_man = 13'h0F0F;
      step();
      rst = 1'b0; ack_man = 1'b0;
      chk("t6_rst_rd", bus.mem_rd, 0);
      chk("t6_rst_valid", bus.instr_valid, 0);
      chk("t6_rst_cnt", bus.fetch_cnt, 0);
      chk("t6_rst_word", bus.instr_word, 0);
      chk("t6_rst_ipc", bus.instr_pc, 0);
      step();
      chk("t6_restart_rd", bus.mem_rd, 1);
      chk("t6_restart_addr", bus.mem_addr, 0);

      // back-to-back zero-wait handshakes: counter saturates at all-ones
      auto_mem = 1'b1; ready = 1'b1;
      repeat (508) step();
      chk("t7_cnt254", bus.fetch_cnt, 8'hFE);
      chk("t7_addr254", bus.mem_addr, 254);
      repeat (92) step();
      chk("t7_sat", bus.fetch_cnt, 8'hFF);
      chk("t7_addr300", bus.mem_addr, 300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multicycle instruction fetch stage sitting directly upstream of the Controller. It owns the PC and IR, and issues read transactions to instruction memory over a req/ack handshake. It presents the fetched word and its opcode to the Controller with a valid/ready handshake. It supports PC redirection for jumps and branches, and discards any fetch that is in flight when a redirect arrives.

Parameters:
DATA_W, 13, instruction word width; opcode = instr_word[DATA_W-1:DATA_W-4]
ADDR_W, 13, PC / memory address width
CNT_W, 16, width of fetched-instruction counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
mem_addr  out  ADDR_W  instruction memory address
mem_rd  out  1  read request; held high until mem_ack
mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack=1
mem_ack  in  1  read complete
instr_word  out  DATA_W  IR contents
opcode  out  4  instr_word[DATA_W-1:DATA_W-4], feeds Controller instruction input
instr_pc  out  ADDR_W  address the IR word was fetched from
instr_valid  out  1  IR holds an unconsumed instruction
instr_ready  in  1  Controller consumes the instruction this cycle
redirect_en  in  1  load new PC (jump/branch taken)
redirect_addr  in  ADDR_W  target address
fetch_cnt  out  CNT_W  count of instructions delivered (handshakes), saturating

Behaviour:
- Single clock domain on clk. rst is synchronous and active-high, sampled at the posedge.
- Reset values: pc=0, IR=0, instr_pc=0, instr_valid=0, mem_rd=0, mem_addr=0, fetch_cnt=0, state=FETCH. The first mem_rd is asserted in the cycle after rst deasserts.
- Reset mid-transaction: the state is abandoned and any later mem_ack is ignored while in reset. Memory is required to tolerate a dropped request.
- mem_addr equals pc in FETCH and equals the latched old address in DRAIN. It is stable for the whole period mem_rd=1.
- mem_rd=1 exactly in states FETCH and DRAIN. mem_ack is only meaningful while mem_rd=1.
- Zero-wait ack is legal: ack in the first cycle mem_rd=1 completes the fetch.
- States and transitions:
  - FETCH:
    - mem_ack=1, redirect_en=0: IR<=mem_rdata, instr_pc<=pc, pc<=pc+1 (wraps modulo 2^ADDR_W), go VALID.
    - mem_ack=0, redirect_en=1: pc<=redirect_addr, go DRAIN.
    - mem_ack=1, redirect_en=1: data discarded, pc<=redirect_addr, stay FETCH (new request next cycle with new address).
    - Otherwise hold.
  - DRAIN: wait for the ack of the stale request.
    - mem_ack=1: data discarded, go FETCH.
    - redirect_en=1: pc<=redirect_addr (last redirect wins). This may coincide with ack.
  - VALID: instr_valid=1, mem_rd=0.
    - instr_ready=1, redirect_en=0: fetch_cnt++ (saturating at all-ones), go FETCH.
    - redirect_en=1: IR invalidated, pc<=redirect_addr, go FETCH. This has priority over instr_ready; no count increment.
- instr_valid is a registered state decode, high only in VALID. instr_word, opcode and instr_pc are stable while instr_valid=1.
- Best-case throughput: one instruction per 2 cycles (FETCH with zero-wait ack, then VALID with ready).
- instr_ready while instr_valid=0 is ignored.

Test Plan:
- Reset then zero-wait memory holding 0x1A05 at addr 0, ready held high: mem_rd=1, mem_addr=0 in cycle 1. instr_valid=1 in cycle 2 with instr_word=0x1A05, opcode=0xD, instr_pc=0. mem_addr=1 in cycle 3. fetch_cnt=1.
- Memory with a 3-cycle ack delay: mem_rd stays high and mem_addr constant for 3 cycles. instr_valid rises the cycle after ack. Ready low for 5 cycles: IR holds, no new mem_rd, fetch_cnt unchanged.
- Redirect to 0x0040 in FETCH at delay cycle 1, ack at cycle 3 with 0x1FFF: no instr_valid from the stale data. The next request has mem_addr=0x0040, and the delivered instr_pc=0x0040.
- Redirect and ready together in VALID (IR from addr 7): instr_valid drops, fetch_cnt not incremented, next mem_addr=redirect_addr. A redirect coincident with ack in FETCH yields an immediate re-request at the new address.
- PC at 0x1FFF with ADDR_W=13: the fetch returns instr_pc=0x1FFF and the next mem_addr=0x0000. With fetch_cnt preloaded near 0xFFFF via 65535 handshakes (CNT_W=16), it saturates at 0xFFFF.
- Assert rst for 1 cycle during DRAIN with ack pending: all outputs return to reset values next cycle, then fetch restarts at addr 0.
